// File: rtl/hdmi_pattern_feeder.sv
`default_nettype none
// ============================================================================
// hdmi_pattern_feeder : valid/ready test-pattern pixel source plus square-wave
// PCM tone. The audio path is present only with HDMI_FEEDER_AUDIO_EN defined.
// Rev 1.0
// ============================================================================
module hdmi_pattern_feeder #(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int SAMPLE_DIV = 1575,
   parameter int TONE_HALF  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  mode,
   output logic [23:0] video_out,
   output logic        video_valid,
   input  logic        video_rdy,
   output logic        frame_start,
   output logic [15:0] audio_out,
   output logic        audio_valid,
   input  logic        audio_rdy,
   output logic [7:0]  audio_overrun
);

   localparam int XW    = $clog2(H_ACTIVE);
   localparam int YW    = $clog2(V_ACTIVE);
   localparam int BAR_W = H_ACTIVE / 8;
   localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
   localparam logic [23:0] BAR_RGB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   function automatic logic [23:0] pattern_f(input logic [1:0]    m,
                                             input logic [XW-1:0] x,
                                             input logic [YW-1:0] y,
                                             input logic [7:0]    f);
      case (m)
         2'd0:    pattern_f = BAR_RGB[3'(x / XW'(BAR_W))];
         2'd1:    pattern_f = {3{8'(x)}};
         2'd2:    pattern_f = (((32'(x) ^ 32'(y)) >> 4) & 32'd1) != 32'd0 ? 24'h000000 : 24'hFFFFFF;
         default: pattern_f = {f, 8'h00, ~f};
      endcase
   endfunction

   // x_q/y_q/frame_q always describe the pixel currently presented
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [7:0]    frame_q, frame_d;
   logic [1:0]    mode_q, mode_d;
   logic [23:0]   video_out_q;
   logic          video_valid_q;
   logic          frame_start_q;
   logic          x_last, y_last, frame_end;

   assign x_last    = (x_q == X_LAST);
   assign y_last    = (y_q == Y_LAST);
   assign frame_end = x_last & y_last;
   assign x_d       = x_last ? '0 : x_q + 1'b1;
   assign y_d       = !x_last ? y_q : (y_last ? '0 : y_q + 1'b1);
   assign frame_d   = frame_end ? frame_q + 8'd1 : frame_q;
   assign mode_d    = frame_end ? mode : mode_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q           <= '0;
         y_q           <= '0;
         frame_q       <= 8'd0;
         mode_q        <= 2'd0;
         video_out_q   <= 24'd0;
         video_valid_q <= 1'b0;
         frame_start_q <= 1'b0;
      end else if (!video_valid_q) begin
         mode_q        <= mode;
         video_out_q   <= pattern_f(mode, '0, '0, 8'd0);
         video_valid_q <= 1'b1;
         frame_start_q <= 1'b1;
      end else if (video_rdy) begin
         x_q           <= x_d;
         y_q           <= y_d;
         frame_q       <= frame_d;
         mode_q        <= mode_d;
         video_out_q   <= pattern_f(mode_d, x_d, y_d, frame_d);
         frame_start_q <= (x_d == '0) && (y_d == '0);
      end
   end

   assign video_out   = video_out_q;
   assign video_valid = video_valid_q;
   assign frame_start = frame_start_q;

`ifdef HDMI_FEEDER_AUDIO_EN
   localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int PW = $clog2(2 * TONE_HALF);
   localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
   localparam logic [PW-1:0] PH_LAST  = PW'(2 * TONE_HALF - 1);
   localparam logic [PW-1:0] PH_HALF  = PW'(TONE_HALF);

   logic [DW-1:0] div_q;
   logic [PW-1:0] phase_q;
   logic [15:0]   audio_out_q;
   logic          audio_valid_q;
   logic [7:0]    overrun_q;
   logic          strobe, audio_xfer;
   logic [15:0]   sample;

   assign strobe     = (div_q == DIV_LAST);
   assign audio_xfer = audio_valid_q & audio_rdy;
   assign sample     = (phase_q < PH_HALF) ? 16'h2000 : 16'hE000;

   // The tone phase advances on every strobe, so dropped samples keep it in step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q         <= '0;
         phase_q       <= '0;
         audio_out_q   <= 16'd0;
         audio_valid_q <= 1'b0;
         overrun_q     <= 8'd0;
      end else begin
         div_q <= strobe ? '0 : div_q + 1'b1;
         if (strobe) begin
            phase_q <= (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
            if (!audio_valid_q || audio_xfer) begin
               audio_out_q   <= sample;
               audio_valid_q <= 1'b1;
            end else if (overrun_q != 8'hFF) begin
               overrun_q <= overrun_q + 8'd1;
            end
         end else if (audio_xfer) begin
            audio_valid_q <= 1'b0;
         end
      end
   end

   assign audio_out     = audio_out_q;
   assign audio_valid   = audio_valid_q;
   assign audio_overrun = overrun_q;
`else
   logic unused_audio;
   assign unused_audio  = audio_rdy ^ (SAMPLE_DIV == 0) ^ (TONE_HALF == 0);
   assign audio_out     = 16'd0;
   assign audio_valid   = 1'b0;
   assign audio_overrun = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hdmi_pattern_feeder.sv
`default_nettype none
// tb_hdmi_pattern_feeder : vector table, corner sequences and a random run
// checked against a transfer-count based reference model.
module tb_hdmi_pattern_feeder;

   localparam int H  = 16;
   localparam int V  = 4;
   localparam int SD = 8;
   localparam int TH = 2;
   localparam int FR = H * V;
   localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [1:0]  mode = 2'd0;
   logic        video_rdy = 1'b0;
   logic        audio_rdy = 1'b0;
   logic [23:0] video_out;
   logic        video_valid;
   logic        frame_start;
   logic [15:0] audio_out;
   logic        audio_valid;
   logic [7:0]  audio_overrun;

   int checks = 0;
   int errors = 0;

   // model: video position is derived from the number of transfers since reset
   bit          m_valid;
   int          m_n;
   int          m_mode;
   int          m_e;
   bit          a_valid;
   logic [15:0] a_out;
   int          a_ovr;

   always #5 clk = ~clk;

   hdmi_pattern_feeder #(.H_ACTIVE(H), .V_ACTIVE(V), .SAMPLE_DIV(SD), .TONE_HALF(TH)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode),
      .video_out(video_out), .video_valid(video_valid), .video_rdy(video_rdy),
      .frame_start(frame_start),
      .audio_out(audio_out), .audio_valid(audio_valid), .audio_rdy(audio_rdy),
      .audio_overrun(audio_overrun)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] ref_pixel(input int md, input int x, input int y, input int f);
      logic [7:0] v;
      logic [7:0] fb;
      v  = x[7:0];
      fb = f[7:0];
      case (md)
         0:       return BARS[x / (H / 8)];
         1:       return {v, v, v};
         2:       return (((x / 16) + (y / 16)) % 2 == 0) ? 24'hFFFFFF : 24'h000000;
         default: return {fb, 8'h00, ~fb};
      endcase
   endfunction

   task automatic model_reset();
      m_valid = 0; m_n = 0; m_mode = 0; m_e = 0;
      a_valid = 0; a_out = 16'd0; a_ovr = 0;
   endtask

   task automatic check_outputs();
      chk("video_valid", 32'(video_valid), 32'(m_valid));
      chk("video_out", 32'(video_out),
          m_valid ? 32'(ref_pixel(m_mode, m_n % H, (m_n / H) % V, (m_n / FR) % 256)) : 32'd0);
      chk("frame_start", 32'(frame_start), 32'(m_valid && (m_n % FR == 0)));
`ifdef HDMI_FEEDER_AUDIO_EN
      chk("audio_valid", 32'(audio_valid), 32'(a_valid));
      chk("audio_out", 32'(audio_out), 32'(a_out));
      chk("audio_overrun", 32'(audio_overrun), 32'(a_ovr));
`else
      chk("audio_valid_off", 32'(audio_valid), 32'd0);
      chk("audio_out_off", 32'(audio_out), 32'd0);
      chk("audio_overrun_off", 32'(audio_overrun), 32'd0);
`endif
   endtask

   // Called at a falling edge: check, advance one rising edge, update the model.
   task automatic step();
      logic       vr, ar, rn, xfer;
      logic [1:0] md;
      int         k;
      logic [15:0] samp;
      check_outputs();
      vr = video_rdy; ar = audio_rdy; md = mode; rn = rst_n;
      @(posedge clk);
      if (!rn) begin
         model_reset();
      end else begin
         if (!m_valid) begin
            m_valid = 1;
            m_mode  = int'(md);
         end else if (vr) begin
            m_n++;
            if (m_n % FR == 0) m_mode = int'(md);
         end
         m_e++;
         xfer = a_valid && ar;
         if (m_e % SD == 0) begin
            k    = m_e / SD;
            samp = (((k - 1) % (2 * TH)) < TH) ? 16'h2000 : 16'hE000;
            if (!a_valid || xfer) begin
               a_out = samp; a_valid = 1;
            end else if (a_ovr < 255) begin
               a_ovr++;
            end
         end else if (xfer) begin
            a_valid = 0;
         end
      end
      @(negedge clk);
   endtask

   // Called at a falling edge; asserts reset mid-cycle and releases it at a falling edge.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1 model_reset();
      chk("rst_video_out", 32'(video_out), 32'd0);
      chk("rst_video_valid", 32'(video_valid), 32'd0);
      chk("rst_frame_start", 32'(frame_start), 32'd0);
      chk("rst_audio_out", 32'(audio_out), 32'd0);
      chk("rst_audio_valid", 32'(audio_valid), 32'd0);
      chk("rst_audio_overrun", 32'(audio_overrun), 32'd0);
      @(negedge clk);
      step();
      step();
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [1:0]  md;
      int          idx;
      logic [23:0] rgb;
      logic        fs;
   } vec_t;

   vec_t vecs [18];

   initial begin
      logic [15:0] samples [$];
      model_reset();
      vecs[0]  = '{2'd0, 0,   24'hFFFFFF, 1'b1};
      vecs[1]  = '{2'd0, 1,   24'hFFFFFF, 1'b0};
      vecs[2]  = '{2'd0, 2,   24'hFFFF00, 1'b0};
      vecs[3]  = '{2'd0, 5,   24'h00FFFF, 1'b0};
      vecs[4]  = '{2'd0, 7,   24'h00FF00, 1'b0};
      vecs[5]  = '{2'd0, 8,   24'hFF00FF, 1'b0};
      vecs[6]  = '{2'd0, 11,  24'hFF0000, 1'b0};
      vecs[7]  = '{2'd0, 13,  24'h0000FF, 1'b0};
      vecs[8]  = '{2'd0, 15,  24'h000000, 1'b0};
      vecs[9]  = '{2'd0, 16,  24'hFFFFFF, 1'b0};
      vecs[10] = '{2'd0, 64,  24'hFFFFFF, 1'b1};
      vecs[11] = '{2'd1, 3,   24'h030303, 1'b0};
      vecs[12] = '{2'd1, 17,  24'h010101, 1'b0};
      vecs[13] = '{2'd2, 5,   24'hFFFFFF, 1'b0};
      vecs[14] = '{2'd3, 0,   24'h0000FF, 1'b1};
      vecs[15] = '{2'd3, 64,  24'h0100FE, 1'b1};
      vecs[16] = '{2'd3, 128, 24'h0200FD, 1'b1};
      vecs[17] = '{2'd3, 63,  24'h0000FF, 1'b0};

      @(negedge clk);

      for (int i = 0; i < 18; i++) begin
         mode = vecs[i].md;
         video_rdy = 1'b1;
         audio_rdy = 1'b1;
         do_reset();
         step();
         for (int j = 0; j < vecs[i].idx; j++) step();
         chk("vec_rgb", 32'(video_out), 32'(vecs[i].rgb));
         chk("vec_frame_start", 32'(frame_start), 32'(vecs[i].fs));
      end

      // stalled gradient: each pixel held across two stall cycles
      mode = 2'd1;
      do_reset();
      step();
      for (int i = 0; i < 96; i++) begin
         video_rdy = (i % 3 == 0);
         step();
      end
      chk("stall_pixel_count", 32'(m_n), 32'd32);

      // mid-frame mode change only takes effect at the next frame
      mode = 2'd3;
      video_rdy = 1'b1;
      do_reset();
      step();
      for (int i = 0; i < 2 * FR + H + 5; i++) step();
      chk("flat_f2_at_5_1", 32'(video_out), 32'h0200FD);
      mode = 2'd2;
      for (int i = 0; i < FR - H - 6; i++) step();
      chk("flat_f2_last", 32'(video_out), 32'h0200FD);
      step();
      chk("checker_f3_first", 32'(video_out), 32'hFFFFFF);
      chk("checker_f3_fs", 32'(frame_start), 32'd1);

      // reset at pixel (9,2) of frame 5
      mode = 2'd0;
      do_reset();
      step();
      for (int i = 0; i < 5 * FR + 2 * H + 9; i++) step();
      chk("pre_reset_pixel", 32'(video_out), 32'(BARS[9 / 2]));
      do_reset();
      step();
      chk("post_reset_valid", 32'(video_valid), 32'd1);
      chk("post_reset_pixel", 32'(video_out), 32'hFFFFFF);
      chk("post_reset_fs", 32'(frame_start), 32'd1);

`ifdef HDMI_FEEDER_AUDIO_EN
      // free-flowing audio: one sample every SD cycles
      video_rdy = 1'b0;
      audio_rdy = 1'b1;
      do_reset();
      for (int i = 0; i < 42; i++) begin
         step();
         if (audio_valid) samples.push_back(audio_out);
      end
      chk("audio_pulse_count", 32'(samples.size()), 32'd5);
      if (samples.size() == 5) begin
         chk("audio_s0", 32'(samples[0]), 32'h2000);
         chk("audio_s1", 32'(samples[1]), 32'h2000);
         chk("audio_s2", 32'(samples[2]), 32'hE000);
         chk("audio_s3", 32'(samples[3]), 32'hE000);
         chk("audio_s4", 32'(samples[4]), 32'h2000);
      end
      chk("audio_no_overrun", 32'(audio_overrun), 32'd0);

      // blocked sink: 300 strobes, overrun saturates, tone phase keeps running
      audio_rdy = 1'b0;
      do_reset();
      for (int i = 0; i < 300 * SD; i++) step();
      chk("blocked_sample", 32'(audio_out), 32'h2000);
      chk("overrun_sat", 32'(audio_overrun), 32'd255);
      audio_rdy = 1'b1;
      for (int i = 0; i < 3 * SD; i++) step();
      chk("resume_valid", 32'(audio_valid), 32'd1);
      chk("resume_sample", 32'(audio_out), 32'hE000);
`endif

      // random traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         mode      = 2'($urandom_range(0, 3));
         video_rdy = ($urandom_range(0, 3) != 0);
         audio_rdy = ($urandom_range(0, 2) != 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
